// File: rtl/dcache_controller.sv
// dcache_controller: sequencing FSM for a direct-mapped, write-through,
// no-write-allocate data cache. Stalls the core during line refills and
// write-throughs, and drives the cache-array and main-memory strobes.
module dcache_controller #(
    parameter int WORDS       = 4,
    parameter int MEM_LATENCY = 3,
    parameter int CNT_W       = 2,
    parameter int IDX_W       = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic [1:0]       mem_write,
    input  logic             hit,
    output logic             stall,
    output logic             cache_we,
    output logic             fill_we,
    output logic [IDX_W-1:0] fill_word,
    output logic             set_valid,
    output logic             mem_rd_req,
    output logic             mem_wr_req,
    output logic [1:0]       mem_wr_size
);

    typedef enum logic [1:0] {IDLE, REFILL, WRITE_MEM, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MEM_LATENCY - 1);
    localparam logic [IDX_W-1:0] WORD_LAST = IDX_W'(WORDS - 1);

    state_t           r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [IDX_W-1:0] r_word, w_word_nx;
    logic [1:0]       r_size, w_size_nx;

    logic             w_stall, w_cache_we, w_fill_we, w_set_valid;
    logic             w_rd_req, w_wr_req;
    logic [IDX_W-1:0] w_fill_word;
    logic [1:0]       w_wr_size;
    logic             w_cnt_last, w_word_last;

    assign w_cnt_last  = (r_cnt == CNT_LAST);
    assign w_word_last = (r_word == WORD_LAST);

    // State and counter registers; reset abandons any operation in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_word  <= '0;
            r_size  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_word  <= w_word_nx;
            r_size  <= w_size_nx;
        end
    end

    // Next-state and raw strobe decode
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_word_nx   = r_word;
        w_size_nx   = r_size;
        w_stall     = 1'b0;
        w_cache_we  = 1'b0;
        w_fill_we   = 1'b0;
        w_fill_word = '0;
        w_set_valid = 1'b0;
        w_rd_req    = 1'b0;
        w_wr_req    = 1'b0;
        w_wr_size   = 2'd0;
        case (r_state)
            IDLE: begin
                // A store wins over a load if the decoder ever raises both
                if (mem_write != 2'd0) begin
                    w_stall    = 1'b1;
                    w_cache_we = hit;
                    w_size_nx  = mem_write;
                    w_cnt_nx   = '0;
                    w_state_nx = WRITE_MEM;
                end else if (mem_read && !hit) begin
                    w_stall    = 1'b1;
                    w_cnt_nx   = '0;
                    w_word_nx  = '0;
                    w_state_nx = REFILL;
                end
            end
            REFILL: begin
                w_stall     = 1'b1;
                w_rd_req    = 1'b1;
                w_fill_word = r_word;
                if (w_cnt_last) begin
                    w_fill_we = 1'b1;
                    w_cnt_nx  = '0;
                    w_word_nx = r_word + IDX_W'(1);
                    if (w_word_last) begin
                        w_set_valid = 1'b1;
                        w_word_nx   = '0;
                        w_state_nx  = DONE;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            WRITE_MEM: begin
                w_stall   = 1'b1;
                w_wr_req  = 1'b1;
                w_wr_size = r_size;
                if (w_cnt_last) begin
                    w_cnt_nx   = '0;
                    w_state_nx = DONE;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            DONE: begin
                w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Outputs are forced low the instant reset asserts, independent of inputs
    always_comb begin
        stall       = rst & w_stall;
        cache_we    = rst & w_cache_we;
        fill_we     = rst & w_fill_we;
        fill_word   = rst ? w_fill_word : '0;
        set_valid   = rst & w_set_valid;
        mem_rd_req  = rst & w_rd_req;
        mem_wr_req  = rst & w_wr_req;
        mem_wr_size = rst ? w_wr_size : 2'd0;
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench: two controllers (MEM_LATENCY=3 and MEM_LATENCY=1) driven
// by independent random streams; expected per-cycle outputs are queued from a
// cycle-list model and popped by per-DUT monitors on the falling edge.
module tb_dcache_controller;

    typedef struct packed {
        logic       stall;
        logic       cwe;
        logic       fwe;
        logic [1:0] fword;
        logic       sv;
        logic       rd;
        logic       wr;
        logic [1:0] size;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      rst_v, rd_v, hit_v;
    logic [1:0][1:0] wr_v;
    wire  [1:0]      stall_v, cwe_v, fwe_v, sv_v, rdq_v, wrq_v;
    wire  [1:0][1:0] fw_v, sz_v;

    int total = 0;
    int bad   = 0;

    rec_t q0[$];
    rec_t q1[$];

    dcache_controller #(.WORDS(4), .MEM_LATENCY(3), .CNT_W(2), .IDX_W(2)) u_dut0 (
        .clk(clk), .rst(rst_v[0]), .mem_read(rd_v[0]), .mem_write(wr_v[0]), .hit(hit_v[0]),
        .stall(stall_v[0]), .cache_we(cwe_v[0]), .fill_we(fwe_v[0]), .fill_word(fw_v[0]),
        .set_valid(sv_v[0]), .mem_rd_req(rdq_v[0]), .mem_wr_req(wrq_v[0]), .mem_wr_size(sz_v[0])
    );

    dcache_controller #(.WORDS(4), .MEM_LATENCY(1), .CNT_W(2), .IDX_W(2)) u_dut1 (
        .clk(clk), .rst(rst_v[1]), .mem_read(rd_v[1]), .mem_write(wr_v[1]), .hit(hit_v[1]),
        .stall(stall_v[1]), .cache_we(cwe_v[1]), .fill_we(fwe_v[1]), .fill_word(fw_v[1]),
        .set_valid(sv_v[1]), .mem_rd_req(rdq_v[1]), .mem_wr_req(wrq_v[1]), .mem_wr_size(sz_v[1])
    );

    function automatic rec_t act_of(input int d);
        rec_t r;
        r.stall = stall_v[d];
        r.cwe   = cwe_v[d];
        r.fwe   = fwe_v[d];
        r.fword = fw_v[d];
        r.sv    = sv_v[d];
        r.rd    = rdq_v[d];
        r.wr    = wrq_v[d];
        r.size  = sz_v[d];
        return r;
    endfunction

    function automatic void chk(input string nm, input int d, input rec_t got, input rec_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t got=%03h exp=%03h", nm, d, $time, got, exp);
        end
    endfunction

    function automatic void push(input int d, input rec_t r);
        if (d == 0) q0.push_back(r); else q1.push_back(r);
    endfunction

    function automatic int qsz(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    // Expected output list for one instruction, cycle by cycle. lim>=0 stops
    // after lim refill cycles (used when reset will cut the refill short).
    function automatic void model(input int d, input logic rd, input logic [1:0] wr,
                                  input logic h, input int lim);
        int   lat;
        rec_t r;
        lat = (d == 0) ? 3 : 1;
        if (wr != 2'd0) begin
            r = '0; r.stall = 1'b1; r.cwe = h; push(d, r);
            for (int i = 0; i < lat; i++) begin
                r = '0; r.stall = 1'b1; r.wr = 1'b1; r.size = wr; push(d, r);
            end
            push(d, '0);
        end else if (rd && !h) begin
            r = '0; r.stall = 1'b1; push(d, r);
            for (int k = 0; k < 4 * lat; k++) begin
                if (lim >= 0 && k >= lim) return;
                r = '0;
                r.stall = 1'b1;
                r.rd    = 1'b1;
                r.fwe   = ((k % lat) == lat - 1);
                r.fword = 2'(k / lat);
                r.sv    = (k == 4 * lat - 1);
                push(d, r);
            end
            push(d, '0);
        end else begin
            push(d, '0);
        end
    endfunction

    // Monitors: one comparison per cycle while expectations are pending
    always @(negedge clk) begin
        if (q0.size() > 0) chk("cycle", 0, act_of(0), q0.pop_front());
    end
    always @(negedge clk) begin
        if (q1.size() > 0) chk("cycle", 1, act_of(1), q1.pop_front());
    end

    task automatic run_op(input int d, input logic rd, input logic [1:0] wr,
                          input logic h, input int lim);
        bit done;
        @(posedge clk);
        #1;
        rd_v[d] = rd; wr_v[d] = wr; hit_v[d] = h;
        model(d, rd, wr, h, lim);
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(posedge clk);
            if (qsz(d) == 0) done = 1'b1;
            else begin
                // hit wiggles while stalled; the controller must ignore it
                #1 hit_v[d] = 1'($urandom_range(0, 1));
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL timeout dut%0d t=%0t got=pending exp=drained", d, $time);
            if (d == 0) q0.delete(); else q1.delete();
        end
        if (lim < 0) begin
            #1 rd_v[d] = 1'b0; wr_v[d] = 2'd0;
        end
    endtask

    task automatic rst_test(input int d);
        int lat;
        lat = (d == 0) ? 3 : 1;
        // Stop right after the second refill word (fill_word=1) is written
        run_op(d, 1'b1, 2'd0, 1'b0, 2 * lat);
        #2 rst_v[d] = 1'b0;
        #1 chk("rst_async", d, act_of(d), '0);
        @(posedge clk);
        #1 chk("rst_hold", d, act_of(d), '0);
        rd_v[d] = 1'b0; hit_v[d] = 1'b0; wr_v[d] = 2'd0;
        #2 rst_v[d] = 1'b1;
        run_op(d, 1'b1, 2'd0, 1'b0, -1);
    endtask

    task automatic run_thread(input int d);
        run_op(d, 1'b1, 2'd0, 1'b1, -1);   // read hit
        run_op(d, 1'b1, 2'd0, 1'b0, -1);   // read miss
        run_op(d, 1'b0, 2'd3, 1'b1, -1);   // word store, hit
        run_op(d, 1'b0, 2'd1, 1'b0, -1);   // byte store, miss
        run_op(d, 1'b1, 2'd2, 1'b0, -1);   // load+half store -> store
        rst_test(d);
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 2))
                0: run_op(d, 1'b0, 2'd0, 1'($urandom_range(0, 1)), -1);
                1: run_op(d, 1'b1, 2'd0, 1'($urandom_range(0, 1)), -1);
                default: run_op(d, 1'($urandom_range(0, 1)), 2'($urandom_range(1, 3)),
                                1'($urandom_range(0, 1)), -1);
            endcase
        end
    endtask

    initial begin
        rst_v = 2'b00; rd_v = 2'b11; hit_v = 2'b00; wr_v = '0;
        #3;
        chk("reset", 0, act_of(0), '0);
        chk("reset", 1, act_of(1), '0);
        @(posedge clk);
        @(posedge clk);
        #1 rd_v = 2'b00;
        #1 rst_v = 2'b11;
        fork
            run_thread(0);
            run_thread(1);
        join
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
